cp0_int_unit: RTL and testbench
===============================

Name: cp0_int_unit

Overview:
- System control coprocessor (CP0) for the pipelined MIPS core.
- Sits directly downstream of the timer/counter and other bridge peripherals, and consumes their IRQ lines as HWInt[7:2].
- Holds SR, Cause, EPC and PRId, services mfc0/mtc0 and eret, and decides each cycle whether the pipeline must take an interrupt or exception.
- The M stage drives it. Its request output flushes the pipeline and redirects fetch to the handler entry.

Parameters:
- PRID, 32'h2017_0801, read-only processor ID value returned for CP0 register 15.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- reset  in  1  synchronous, active-low reset. reset==0 at posedge clears state.
- A1  in  5  CP0 register number read by mfc0.
- A2  in  5  CP0 register number written by mtc0.
- DIn  in  32  mtc0 write data.
- WE  in  1  mtc0 write enable.
- PC  in  32  PC of the instruction currently in M stage.
- BD  in  1  M-stage instruction is in a branch delay slot.
- ExcCode  in  5  synchronous exception code from the pipeline. 0 = none.
- HWInt  in  6  hardware interrupt lines [7:2]. Bit 2 = timer0 IRQ, bit 3 = timer1 IRQ, bit 4 = external device.
- EXLClr  in  1  eret in M stage; clears SR.EXL.
- Dout  out  32  combinational read of register A1.
- EPC  out  32  current EPC, used by eret as the return target.
- Req  out  1  combinational take-exception request to the pipeline.

Behaviour:
- Register map: 12=SR, 13=Cause, 14=EPC, 15=PRId. Any other A1 reads 0.
- SR fields: IM[15:10], EXL[1], IE[0]. All other bits read 0.
- Cause fields: BD[31], IP[15:10], ExcCode[6:2]. All other bits read 0.
- Reset (reset==0 at posedge): SR=0, Cause=0, EPC=0. Consequently Req=0, Dout follows the cleared registers, and EPC out=0.
- Cause.IP <= HWInt every non-reset cycle, regardless of other events.
- Interrupt pending IntP = |(HWInt & SR.IM) & SR.IE & ~SR.EXL, evaluated on live HWInt.
- Exception pending ExcP = (ExcCode != 0) & ~SR.EXL.
- Req = IntP | ExcP. Purely combinational, zero latency.
- On posedge with Req=1:
  - SR.EXL <= 1.
  - Cause.BD <= BD.
  - Cause.ExcCode <= IntP ? 0 : ExcCode. Interrupt has priority over exception.
  - EPC <= BD ? {PC[31:2],2'b00} - 4 : {PC[31:2],2'b00}.
- mtc0 (WE=1) with Req=0:
  - A2=12 writes SR.IM, SR.EXL and SR.IE from DIn; other SR bits are unaffected.
  - A2=14 writes EPC <= {DIn[31:2],2'b00}.
  - Writes to 13, 15 and all other numbers are ignored.
- mtc0 in the same cycle as Req=1 is discarded. The faulting instruction does not commit.
- EXLClr=1 with Req=0 sets SR.EXL <= 0 at the posedge.
- EXLClr and WE both targeting SR in the same cycle: EXLClr wins for the EXL bit; IM and IE are taken from DIn.
- EXLClr with Req=1 cannot occur because EXL=1 masks Req. If it does occur anyway, Req handling takes precedence.
- Nested events are masked while EXL=1. A level-sensitive HWInt still asserted after eret re-raises Req in the first cycle after EXL clears.
- Dout and EPC reflect register values before the posedge update; there is no internal bypass.
- EPC arithmetic is 32-bit wrap-around: BD=1 with PC=0 gives EPC=32'hFFFF_FFFC.

Test Plan:
- Reset: hold reset=0 for 2 cycles, then read A1=12/13/14/15 -> 0, 0, 0, 32'h2017_0801; Req=0.
- Timer interrupt:
  - Stimulus: mtc0 SR=32'h0000_0401 (IM[10]=1, IE=1), PC=32'h0000_3010, BD=0, then HWInt=6'b000001.
  - Required: Req=1 in the same cycle. After the edge, SR=32'h0000_0403, Cause=32'h0000_0400, EPC=32'h0000_3010.
- Delay-slot exception:
  - Stimulus: SR=0, ExcCode=5'd10, BD=1, PC=32'h0000_3020.
  - Required: Req=1. After the edge, Cause=32'h8000_0028, EPC=32'h0000_301C, EXL=1.
- Masking and priority:
  - Stimulus: with EXL=1, drive ExcCode=4 and HWInt=6'b111111.
  - Required: Req=0 and no register change except IP.
  - Then: with EXL=0, IE=1, IM[10]=1, drive HWInt[2]=1 and ExcCode=4 together.
  - Required: ExcCode latched = 0.
- eret/mtc0 interplay:
  - Stimulus: EXL=1, EXLClr=1, WE=1, A2=12, DIn=32'h0000_FC03.
  - Required: SR=32'h0000_FC01 after the edge. If HWInt is still high, Req=1 in the next cycle.
- Write masking: mtc0 A2=13 with DIn=32'hFFFF_FFFF, then mtc0 A2=14 with DIn=32'h1234_5677 -> Cause unchanged; EPC=32'h1234_5674.

Source files
------------

// File: rtl/cp0_int_unit_if.sv
// cp0_int_unit_if: M-stage pipeline <-> CP0 register access, exception and interrupt request signals
interface cp0_int_unit_if;
  logic [4:0]  A1;
  logic [4:0]  A2;
  logic [31:0] DIn;
  logic        WE;
  logic [31:0] PC;
  logic        BD;
  logic [4:0]  ExcCode;
  logic [5:0]  HWInt;
  logic        EXLClr;
  logic [31:0] Dout;
  logic [31:0] EPC;
  logic        Req;
  modport master (output A1, A2, DIn, WE, PC, BD, ExcCode, HWInt, EXLClr, input Dout, EPC, Req);
  modport slave (input A1, A2, DIn, WE, PC, BD, ExcCode, HWInt, EXLClr, output Dout, EPC, Req);
endinterface

// File: rtl/cp0_int_unit.sv
// cp0_int_unit: MIPS CP0 holding SR/Cause/EPC/PRId, serving mfc0/mtc0/eret and raising the exception request
module cp0_int_unit #(
  parameter logic [31:0] PRID = 32'h2017_0801
) (
  input logic clk,
  input logic reset,
  cp0_int_unit_if.slave bus
);
  logic [5:0]  im_q, im_d, ip_q, ip_d;
  logic        exl_q, exl_d, ie_q, ie_d, bd_q, bd_d;
  logic [4:0]  exc_q, exc_d;
  logic [31:0] epc_q, epc_d, pc_al, sr, cause;
  logic        int_p, exc_p, req, sr_we, epc_we;
  always_comb begin
    int_p  = (|(bus.HWInt & im_q)) & ie_q & ~exl_q;
    exc_p  = (bus.ExcCode != '0) & ~exl_q;
    req    = int_p | exc_p;
    pc_al  = {bus.PC[31:2], 2'b00};
    sr_we  = bus.WE & ~req & (bus.A2 == 5'd12);
    epc_we = bus.WE & ~req & (bus.A2 == 5'd14);
    im_d   = sr_we ? bus.DIn[15:10] : im_q;
    ie_d   = sr_we ? bus.DIn[0] : ie_q;
    exl_d  = req ? 1'b1 : bus.EXLClr ? 1'b0 : sr_we ? bus.DIn[1] : exl_q;
    bd_d   = req ? bus.BD : bd_q;
    exc_d  = req ? (int_p ? 5'd0 : bus.ExcCode) : exc_q;
    ip_d   = bus.HWInt;
    epc_d  = req ? (bus.BD ? pc_al - 32'd4 : pc_al) : epc_we ? {bus.DIn[31:2], 2'b00} : epc_q;
    sr     = {16'b0, im_q, 8'b0, exl_q, ie_q};
    cause  = {bd_q, 15'b0, ip_q, 3'b0, exc_q, 2'b0};
    bus.Dout = bus.A1 == 5'd12 ? sr :
               bus.A1 == 5'd13 ? cause :
               bus.A1 == 5'd14 ? epc_q :
               bus.A1 == 5'd15 ? PRID : 32'd0;
    bus.EPC = epc_q;
    bus.Req = req;
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      im_q  <= '0;
      ip_q  <= '0;
      exl_q <= 1'b0;
      ie_q  <= 1'b0;
      bd_q  <= 1'b0;
      exc_q <= '0;
      epc_q <= '0;
    end else begin
      im_q  <= im_d;
      ip_q  <= ip_d;
      exl_q <= exl_d;
      ie_q  <= ie_d;
      bd_q  <= bd_d;
      exc_q <= exc_d;
      epc_q <= epc_d;
    end
  end
endmodule

// File: tb/tb_cp0_int_unit.sv
// tb_cp0_int_unit: directed plus randomized check of cp0_int_unit against a word-level CP0 model
module tb_cp0_int_unit;
  localparam logic [31:0] PRID = 32'h2017_0801;
  logic clk = 1'b0;
  logic reset;
  int vectors = 0;
  int miscompares = 0;
  logic [31:0] m_sr, m_cause, m_epc;
  cp0_int_unit_if bus();
  cp0_int_unit dut (.clk(clk), .reset(reset), .bus(bus.slave));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask
  function automatic logic m_intp();
    return ((bus.HWInt & m_sr[15:10]) != 6'd0) && m_sr[0] && !m_sr[1];
  endfunction
  function automatic logic m_req();
    return m_intp() || (bus.ExcCode != 5'd0 && !m_sr[1]);
  endfunction
  function automatic logic [31:0] m_read(input logic [4:0] a);
    return a == 5'd12 ? m_sr : a == 5'd13 ? m_cause : a == 5'd14 ? m_epc : a == 5'd15 ? PRID : 32'd0;
  endfunction
  task automatic set_in(input logic we, input logic [4:0] a2, input logic [31:0] din,
                        input logic [31:0] pc, input logic bd, input logic [4:0] ec,
                        input logic [5:0] hw, input logic clr);
    bus.WE = we; bus.A2 = a2; bus.DIn = din; bus.PC = pc; bus.BD = bd;
    bus.ExcCode = ec; bus.HWInt = hw; bus.EXLClr = clr;
  endtask
  task automatic tick(input string tag, input bit chk);
    int a1s[5];
    logic ip, rq;
    a1s = '{12, 13, 14, 15, int'($urandom_range(0, 31))};
    for (int i = 0; i < 5; i++) begin
      bus.A1 = a1s[i][4:0];
      #1;
      if (chk) check($sformatf("%s.dout[%0d]", tag, a1s[i]), bus.Dout, m_read(bus.A1));
    end
    ip = m_intp();
    rq = m_req();
    if (chk) begin
      check({tag, ".req"}, {31'd0, bus.Req}, {31'd0, rq});
      check({tag, ".epc"}, bus.EPC, m_epc);
    end
    @(posedge clk);
    if (!reset) begin
      m_sr = 0; m_cause = 0; m_epc = 0;
    end else begin
      m_cause[15:10] = bus.HWInt;
      if (rq) begin
        m_sr[1] = 1'b1;
        m_cause[31] = bus.BD;
        m_cause[6:2] = ip ? 5'd0 : bus.ExcCode;
        m_epc = {bus.PC[31:2], 2'b00} - (bus.BD ? 32'd4 : 32'd0);
      end else begin
        if (bus.WE && bus.A2 == 5'd12) m_sr = bus.DIn & 32'h0000_FC03;
        if (bus.EXLClr) m_sr[1] = 1'b0;
        if (bus.WE && bus.A2 == 5'd14) m_epc = bus.DIn & 32'hFFFF_FFFC;
      end
    end
    #1;
  endtask
  initial begin
    m_sr = 0; m_cause = 0; m_epc = 0;
    bus.A1 = 0;
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    reset = 0;
    tick("rst0", 0);
    tick("rst1", 0);
    reset = 1;
    tick("reset", 1);
    set_in(1, 12, 32'h0000_0401, 0, 0, 0, 0, 0);
    tick("wr_sr", 1);
    set_in(0, 0, 0, 32'h0000_3010, 0, 0, 6'b000001, 0);
    tick("timer", 1);
    tick("timer_post", 1);
    check("timer.sr", m_sr, 32'h0000_0403);
    check("timer.cause", m_cause, 32'h0000_0400);
    set_in(1, 12, 32'h0000_0000, 0, 0, 0, 0, 0);
    tick("clr_sr", 1);
    set_in(0, 0, 0, 32'h0000_3020, 1, 5'd10, 0, 0);
    tick("dslot", 1);
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    tick("dslot_post", 1);
    check("dslot.model_epc", m_epc, 32'h0000_301C);
    set_in(0, 0, 0, 32'h0000_4000, 0, 5'd4, 6'b111111, 0);
    tick("masked", 1);
    set_in(0, 0, 0, 0, 0, 0, 6'b111111, 0);
    tick("masked_post", 1);
    set_in(1, 12, 32'h0000_0401, 0, 0, 0, 0, 0);
    tick("rearm", 1);
    set_in(0, 0, 0, 32'h0000_5000, 0, 5'd4, 6'b000001, 0);
    tick("prio", 1);
    tick("prio_post", 1);
    set_in(1, 12, 32'h0000_FC03, 0, 0, 0, 6'b000001, 1);
    tick("eret_wr", 1);
    check("eret.model_sr", m_sr, 32'h0000_FC01);
    tick("reraise", 1);
    set_in(1, 13, 32'hFFFF_FFFF, 0, 0, 0, 0, 0);
    tick("wr_cause", 1);
    set_in(1, 14, 32'h1234_5677, 0, 0, 0, 0, 0);
    tick("wr_epc", 1);
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    tick("wr_post", 1);
    set_in(0, 0, 0, 0, 0, 0, 0, 1);
    tick("eret", 1);
    set_in(0, 0, 0, 32'h0000_0000, 1, 5'd1, 0, 0);
    tick("wrap", 1);
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    tick("wrap_post", 1);
    for (int n = 0; n < 400; n++) begin
      reset = ($urandom_range(0, 49) != 0);
      set_in($urandom_range(0, 2) == 0,
             $urandom_range(0, 3) == 0 ? 5'($urandom_range(0, 31)) : 5'($urandom_range(12, 15)),
             $urandom, $urandom, 1'($urandom_range(0, 1)),
             $urandom_range(0, 3) == 0 ? 5'($urandom_range(1, 31)) : 5'd0,
             $urandom_range(0, 1) == 0 ? 6'($urandom) : 6'd0,
             $urandom_range(0, 3) == 0);
      tick("rand", 1);
    end
    reset = 1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
